// File: rtl/upc_pkg.sv
// Shared opcode encoding and microword field geometry for upc_sequencer.
// Latency: none (types and constant functions only).
// Backpressure: n/a. UPC_PARITY_EN adds one even-parity bit to each stored word.
package upc_pkg;

    typedef enum logic [2:0] {
        OP_CONT  = 3'd0,
        OP_JMPC  = 3'd1,
        OP_JMP   = 3'd2,
        OP_CALL  = 3'd3,
        OP_CALLC = 3'd4,
        OP_RET   = 3'd5,
        OP_RETC  = 3'd6,
        OP_HALT  = 3'd7
    } op_e;

    localparam int OP_W = 3;

`ifdef UPC_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // A single condition still needs one select bit so the field never vanishes.
    function automatic int sel_w(input int cond_n);
        return (cond_n > 1) ? $clog2(cond_n) : 1;
    endfunction

    // Layout MSB..LSB: op | sel | pol | addr | ctrl
    function automatic int word_w(input int addr_w, input int sw, input int ctrl_w);
        return OP_W + sw + 1 + addr_w + ctrl_w;
    endfunction

    function automatic int prog_w(input int addr_w, input int sw, input int ctrl_w);
        return word_w(addr_w, sw, ctrl_w) + PAR_W;
    endfunction

    function automatic int addr_lsb(input int ctrl_w);
        return ctrl_w;
    endfunction

    function automatic int pol_bit(input int addr_w, input int ctrl_w);
        return ctrl_w + addr_w;
    endfunction

    function automatic int sel_lsb(input int addr_w, input int ctrl_w);
        return ctrl_w + addr_w + 1;
    endfunction

    function automatic int op_lsb(input int addr_w, input int sw, input int ctrl_w);
        return ctrl_w + addr_w + 1 + sw;
    endfunction

endpackage

// File: rtl/upc_sequencer_if.sv
// Bus bundle between a datapath/loader (master) and upc_sequencer (slave).
// Latency: none (wires only).
// Backpressure: hold from the master freezes the sequencer; no ready signalling.
// Ports: hold, cond, prog_we/prog_addr/prog_data in; ctrl_bus, upc, halted,
// stk_err, parity_err out. prog_data carries the parity bit under UPC_PARITY_EN.
interface upc_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 7,
    parameter int COND_N = 4
);
    import upc_pkg::*;

    localparam int SEL_W  = sel_w(COND_N);
    localparam int PROG_W = prog_w(ADDR_W, SEL_W, CTRL_W);

    logic                hold;
    logic [COND_N-1:0]   cond;
    logic                prog_we;
    logic [ADDR_W-1:0]   prog_addr;
    logic [PROG_W-1:0]   prog_data;
    logic [CTRL_W-1:0]   ctrl_bus;
    logic [ADDR_W-1:0]   upc;
    logic                halted;
    logic                stk_err;
    logic                parity_err;

    modport master (
        output hold, cond, prog_we, prog_addr, prog_data,
        input  ctrl_bus, upc, halted, stk_err, parity_err
    );

    modport slave (
        input  hold, cond, prog_we, prog_addr, prog_data,
        output ctrl_bus, upc, halted, stk_err, parity_err
    );

endinterface

// File: rtl/upc_stack.sv
// Return-address LIFO, STACK_D entries of ADDR_W bits.
// Latency: push/pop take effect on the clock edge; o_top is combinational.
// Backpressure: push while full and pop while empty are ignored; caller checks o_full/o_empty.
module upc_stack #(
    parameter int STACK_D = 4,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_dat,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_full,
    output logic              o_empty
);
    localparam int SP_W  = $clog2(STACK_D + 1);
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    logic [ADDR_W-1:0] r_mem [STACK_D];
    logic [SP_W-1:0]   r_sp;

    assign o_full  = (32'(r_sp) == STACK_D);
    assign o_empty = (r_sp == '0);
    // Only meaningful when not empty; the caller never pops an empty stack.
    assign o_top   = r_mem[IDX_W'(r_sp - SP_W'(1))];

    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[IDX_W'(r_sp)] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/upc_sequencer.sv
// Microprogrammed controller: writable store, conditional branch, call/return, halt.
// Latency: ctrl_bus shows the word at upc one clock after it is fetched.
// Backpressure: hold freezes all state; halt stops until reset; loads accepted always.
// Ports: clk, rst_n (async active-low), sif (slave modport of upc_sequencer_if).
// UPC_PARITY_EN: adds an even-parity bit per word; a bad fetch halts with parity_err.
module upc_sequencer
    import upc_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int CTRL_W  = 7,
    parameter int COND_N  = 4,
    parameter int STACK_D = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    upc_sequencer_if.slave sif
);
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int SEL_W    = sel_w(COND_N);
    localparam int WORD_W   = word_w(ADDR_W, SEL_W, CTRL_W);
    localparam int PROG_W   = WORD_W + PAR_W;
    localparam int ADDR_LSB = addr_lsb(CTRL_W);
    localparam int POL_BIT  = pol_bit(ADDR_W, CTRL_W);
    localparam int SEL_LSB  = sel_lsb(ADDR_W, CTRL_W);
    localparam int OP_LSB   = op_lsb(ADDR_W, SEL_W, CTRL_W);

    logic [PROG_W-1:0] r_store [DEPTH];
    logic [ADDR_W-1:0] r_upc;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_halted;
    logic              r_stk_err;

    logic [PROG_W-1:0] w_word;
    op_e               w_op;
    logic [SEL_W-1:0]  w_sel;
    logic              w_pol;
    logic [ADDR_W-1:0] w_addr;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_cond;
    logic              w_run;
    logic [ADDR_W-1:0] w_upc_inc;
    logic [ADDR_W-1:0] w_upc_nxt;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic              w_halt_nxt;
    logic              w_err_nxt;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_stk_top;
    logic              w_stk_full;
    logic              w_stk_empty;
`ifdef UPC_PARITY_EN
    logic              w_par_bad;
    logic              r_par_err;
`endif

    // Store has no reset; the combinational read below sees the pre-write word.
    always_ff @(posedge clk) begin
        if (sif.prog_we) begin
            r_store[sif.prog_addr] <= sif.prog_data;
        end
    end

    assign w_word    = r_store[r_upc];
    assign w_op      = op_e'(w_word[OP_LSB +: OP_W]);
    assign w_sel     = w_word[SEL_LSB +: SEL_W];
    assign w_pol     = w_word[POL_BIT];
    assign w_addr    = w_word[ADDR_LSB +: ADDR_W];
    assign w_ctrl    = w_word[CTRL_W-1:0];
    assign w_upc_inc = r_upc + ADDR_W'(1);
    assign w_run     = !sif.hold && !r_halted;
    // Unimplemented select codes read a deasserted flag before polarity.
    assign w_cond    = ((32'(w_sel) < COND_N) ? sif.cond[w_sel] : 1'b0) ^ w_pol;

    upc_stack #(
        .STACK_D (STACK_D),
        .ADDR_W  (ADDR_W)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (w_upc_inc),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    always_comb begin
        w_upc_nxt  = w_upc_inc;
        w_ctrl_nxt = w_ctrl;
        w_halt_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        case (w_op)
            OP_CONT: begin
            end
            OP_JMPC: begin
                if (w_cond) w_upc_nxt = w_addr;
            end
            OP_JMP: begin
                w_upc_nxt = w_addr;
            end
            OP_CALL, OP_CALLC: begin
                if (w_op == OP_CALL || w_cond) begin
                    // Overflowing call degrades to CONT and flags the error.
                    if (w_stk_full) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_push    = 1'b1;
                        w_upc_nxt = w_addr;
                    end
                end
            end
            OP_RET, OP_RETC: begin
                if (w_op == OP_RET || w_cond) begin
                    if (w_stk_empty) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_pop     = 1'b1;
                        w_upc_nxt = w_stk_top;
                    end
                end
            end
            OP_HALT: begin
                w_upc_nxt  = r_upc;
                w_halt_nxt = 1'b1;
            end
            default: begin
            end
        endcase
`ifdef UPC_PARITY_EN
        // Corrupt word overrides whatever it decoded to: blank control and stop.
        w_par_bad = ^w_word;
        if (w_par_bad) begin
            w_upc_nxt  = r_upc;
            w_ctrl_nxt = '0;
            w_halt_nxt = 1'b1;
            w_err_nxt  = 1'b0;
            w_push     = 1'b0;
            w_pop      = 1'b0;
        end
`endif
        if (!w_run) begin
            w_push = 1'b0;
            w_pop  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upc     <= '0;
            r_ctrl    <= '0;
            r_halted  <= 1'b0;
            r_stk_err <= 1'b0;
        end else if (w_run) begin
            r_upc  <= w_upc_nxt;
            r_ctrl <= w_ctrl_nxt;
            if (w_halt_nxt) r_halted  <= 1'b1;
            if (w_err_nxt)  r_stk_err <= 1'b1;
        end
    end

`ifdef UPC_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if (w_run && w_par_bad) begin
            r_par_err <= 1'b1;
        end
    end
    assign sif.parity_err = r_par_err;
`else
    assign sif.parity_err = 1'b0;
`endif

    assign sif.ctrl_bus = r_ctrl;
    assign sif.upc      = r_upc;
    assign sif.halted   = r_halted;
    assign sif.stk_err  = r_stk_err;

endmodule

// File: tb/tb_upc_sequencer.sv
// Self-checking bench for upc_sequencer: directed scenarios plus randomized programs
// compared every cycle against a queue-based behavioural model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_upc_sequencer;
    localparam int AW    = 4;
    localparam int CW    = 7;
    localparam int CN    = 4;
    localparam int SD    = 4;
    localparam int DEPTH = 16;
    localparam int SW    = 2;
    localparam int WW    = 17;
`ifdef UPC_PARITY_EN
    localparam int PW    = WW + 1;
`else
    localparam int PW    = WW;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    upc_sequencer_if #(.ADDR_W(AW), .CTRL_W(CW), .COND_N(CN)) u_if ();

    upc_sequencer #(
        .ADDR_W  (AW),
        .CTRL_W  (CW),
        .COND_N  (CN),
        .STACK_D (SD)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    logic [PW-1:0] m_store [DEPTH];
    int            m_upc;
    int            m_ctrl;
    bit            m_halt;
    bit            m_serr;
    bit            m_perr;
    int            m_stk [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [WW-1:0] mkw(input int op, input int sel, input int pol,
                                          input int addr, input int ctrl);
        return {3'(op), SW'(sel), 1'(pol), AW'(addr), CW'(ctrl)};
    endfunction

    function automatic logic [PW-1:0] to_prog(input logic [WW-1:0] w);
`ifdef UPC_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    function automatic logic [WW-1:0] rand_word();
        int op;
        op = $urandom_range(0, 6);
        if ($urandom_range(0, 30) == 0) op = 7;
        return mkw(op, $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, DEPTH - 1), $urandom_range(0, 127));
    endfunction

    task automatic model_reset();
        m_upc  = 0;
        m_ctrl = 0;
        m_halt = 0;
        m_serr = 0;
        m_perr = 0;
        m_stk.delete();
    endtask

    // One rising edge of the reference machine, using the inputs currently driven.
    task automatic model_edge();
        logic [PW-1:0] w;
        int op, sel, pol, addr, ctrl, inc, nxt;
        bit c, bad;
        if (rst_n && !u_if.hold && !m_halt) begin
            w    = m_store[m_upc];
            op   = int'(w[16:14]);
            sel  = int'(w[13:12]);
            pol  = int'(w[11]);
            addr = int'(w[10:7]);
            ctrl = int'(w[6:0]);
            inc  = (m_upc + 1) % DEPTH;
            c    = ((sel < CN) ? u_if.cond[sel] : 1'b0) ^ pol[0];
            bad  = 1'b0;
`ifdef UPC_PARITY_EN
            bad  = ^w;
`endif
            if (bad) begin
                m_ctrl = 0;
                m_halt = 1;
                m_perr = 1;
            end else begin
                nxt = inc;
                case (op)
                    1: if (c) nxt = addr;
                    2: nxt = addr;
                    3, 4: if (op == 3 || c) begin
                        if (m_stk.size() >= SD) m_serr = 1;
                        else begin
                            m_stk.push_back(inc);
                            nxt = addr;
                        end
                    end
                    5, 6: if (op == 5 || c) begin
                        if (m_stk.size() == 0) m_serr = 1;
                        else nxt = m_stk.pop_back();
                    end
                    7: begin
                        nxt    = m_upc;
                        m_halt = 1;
                    end
                    default: ;
                endcase
                m_ctrl = ctrl;
                m_upc  = nxt;
            end
        end
        if (u_if.prog_we) m_store[u_if.prog_addr] = u_if.prog_data;
    endtask

    task automatic cmp_model(input string tag);
        check_eq({tag, "_upc"},  32'(u_if.upc),        32'(m_upc));
        check_eq({tag, "_ctrl"}, 32'(u_if.ctrl_bus),   32'(m_ctrl));
        check_eq({tag, "_hlt"},  32'(u_if.halted),     32'(m_halt));
        check_eq({tag, "_serr"}, 32'(u_if.stk_err),    32'(m_serr));
        check_eq({tag, "_perr"}, 32'(u_if.parity_err), 32'(m_perr));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step("rst");
        rst_n = 1'b1;
    endtask

    task automatic load_raw(input int a, input logic [PW-1:0] d);
        u_if.prog_we   = 1'b1;
        u_if.prog_addr = AW'(a);
        u_if.prog_data = d;
        step("ld");
        u_if.prog_we   = 1'b0;
    endtask

    task automatic load(input int a, input logic [WW-1:0] w);
        load_raw(a, to_prog(w));
    endtask

    initial begin
        u_if.hold      = 1'b1;
        u_if.cond      = '0;
        u_if.prog_we   = 1'b0;
        u_if.prog_addr = '0;
        u_if.prog_data = '0;
        model_reset();

        // Basic run to HALT
        do_reset();
        check_eq("rst_upc",  32'(u_if.upc), 0);
        check_eq("rst_ctrl", 32'(u_if.ctrl_bus), 0);
        check_eq("rst_hlt",  32'(u_if.halted), 0);
        check_eq("rst_serr", 32'(u_if.stk_err), 0);
        check_eq("rst_perr", 32'(u_if.parity_err), 0);
        load(0, mkw(0, 0, 0, 0, 'h06));
        load(1, mkw(0, 0, 0, 0, 'h40));
        load(2, mkw(7, 0, 0, 0, 'h38));
        u_if.hold = 1'b0;
        step("t1"); check_eq("t1_c0", 32'(u_if.ctrl_bus), 'h06);
        step("t1"); check_eq("t1_c1", 32'(u_if.ctrl_bus), 'h40);
        step("t1"); check_eq("t1_c2", 32'(u_if.ctrl_bus), 'h38);
        step("t1");
        check_eq("t1_hlt", 32'(u_if.halted), 1);
        check_eq("t1_upc", 32'(u_if.upc), 2);

        // Conditional jump with select and polarity
        u_if.hold = 1'b1;
        do_reset();
        load(0, mkw(0, 0, 0, 0, 'h01));
        load(1, mkw(0, 0, 0, 0, 'h02));
        load(2, mkw(0, 0, 0, 0, 'h03));
        load(3, mkw(1, 1, 0, 5, 'h04));
        load(4, mkw(7, 0, 0, 0, 'h14));
        load(5, mkw(7, 0, 0, 0, 'h15));
        u_if.hold = 1'b0;
        u_if.cond = 4'b0010;
        repeat (4) step("t2a");
        check_eq("t2_taken", 32'(u_if.upc), 5);
        u_if.hold = 1'b1;
        do_reset();
        u_if.hold = 1'b0;
        u_if.cond = 4'b0000;
        repeat (4) step("t2b");
        check_eq("t2_fall", 32'(u_if.upc), 4);
        u_if.hold = 1'b1;
        do_reset();
        load(3, mkw(1, 1, 1, 5, 'h04));
        u_if.hold = 1'b0;
        repeat (4) step("t2c");
        check_eq("t2_inv", 32'(u_if.upc), 5);

        // Call and return
        u_if.hold = 1'b1;
        do_reset();
        load(0, mkw(3, 0, 0, 8, 'h11));
        load(1, mkw(7, 0, 0, 0, 'h12));
        load(8, mkw(0, 0, 0, 0, 'h18));
        load(9, mkw(5, 0, 0, 0, 'h19));
        u_if.hold = 1'b0;
        step("t3"); check_eq("t3_u8", 32'(u_if.upc), 8);
        step("t3"); check_eq("t3_u9", 32'(u_if.upc), 9);
        step("t3"); check_eq("t3_u1", 32'(u_if.upc), 1);
        check_eq("t3_serr", 32'(u_if.stk_err), 0);

        // Stack overflow on the fifth nested call
        u_if.hold = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) load(2 * i, mkw(3, 0, 0, 2 * i + 2, i + 1));
        load(9,  mkw(7, 0, 0, 0, 'h29));
        load(10, mkw(7, 0, 0, 0, 'h2a));
        u_if.hold = 1'b0;
        repeat (5) step("t4");
        check_eq("t4_ovf_upc",  32'(u_if.upc), 9);
        check_eq("t4_ovf_serr", 32'(u_if.stk_err), 1);

        // Underflow: return with an empty stack
        u_if.hold = 1'b1;
        do_reset();
        check_eq("t4_rst_serr", 32'(u_if.stk_err), 0);
        load(0, mkw(5, 0, 0, 0, 'h21));
        load(1, mkw(7, 0, 0, 0, 'h22));
        u_if.hold = 1'b0;
        step("t4u");
        check_eq("t4_unf_upc",  32'(u_if.upc), 1);
        check_eq("t4_unf_serr", 32'(u_if.stk_err), 1);

        // Hold freezes, then asynchronous reset between edges
        u_if.hold = 1'b1;
        do_reset();
        load(0, mkw(0, 0, 0, 0, 'h31));
        load(1, mkw(0, 0, 0, 0, 'h32));
        load(2, mkw(0, 0, 0, 0, 'h33));
        load(3, mkw(2, 0, 0, 0, 'h34));
        u_if.hold = 1'b0;
        repeat (2) step("t5");
        u_if.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("t5h");
            check_eq("t5_hold_upc",  32'(u_if.upc), 2);
            check_eq("t5_hold_ctrl", 32'(u_if.ctrl_bus), 'h32);
        end
        u_if.hold = 1'b0;
        step("t5");
        check_eq("t5_resume", 32'(u_if.upc), 3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("t5_arst_ctrl", 32'(u_if.ctrl_bus), 0);
        check_eq("t5_arst_upc",  32'(u_if.upc), 0);
        step("t5r");
        rst_n = 1'b1;
        step("t5x");
        check_eq("t5_first_ctrl", 32'(u_if.ctrl_bus), 'h31);
        check_eq("t5_first_upc",  32'(u_if.upc), 1);

`ifdef UPC_PARITY_EN
        // Corrupt parity on word 2
        u_if.hold = 1'b1;
        do_reset();
        load(0, mkw(0, 0, 0, 0, 'h41));
        load(1, mkw(0, 0, 0, 0, 'h42));
        begin
            logic [WW-1:0] pw;
            pw = mkw(0, 0, 0, 0, 'h43);
            load_raw(2, {~(^pw), pw});
        end
        u_if.hold = 1'b0;
        repeat (3) step("tp");
        check_eq("tp_ctrl", 32'(u_if.ctrl_bus), 0);
        check_eq("tp_hlt",  32'(u_if.halted), 1);
        check_eq("tp_perr", 32'(u_if.parity_err), 1);
        check_eq("tp_upc",  32'(u_if.upc), 2);
`endif

        // Randomized programs with random conditions, holds and live loads
        for (int r = 0; r < 6; r++) begin
            u_if.hold = 1'b1;
            do_reset();
            for (int a = 0; a < DEPTH; a++) load(a, rand_word());
            u_if.hold = 1'b0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                u_if.cond      = CN'($urandom);
                u_if.hold      = ($urandom_range(0, 9) == 0);
                u_if.prog_we   = ($urandom_range(0, 9) == 0);
                u_if.prog_addr = AW'($urandom_range(0, DEPTH - 1));
                u_if.prog_data = to_prog(rand_word());
`ifdef UPC_PARITY_EN
                if ($urandom_range(0, 19) == 0) u_if.prog_data[WW] = ~u_if.prog_data[WW];
`endif
                step("rnd");
            end
            u_if.prog_we = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
